uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

- Shares one UART transmitter between `NUM_REQ` byte-stream requesters using packet-locked round-robin arbitration.
- Optionally prefixes each packet with a source-ID header byte.
- Sits between the requesters (e.g. telemetry, command responses, debug) and the `write_*` ready/valid port of the full-duplex UART.
- Holds `uart_write_data` stable for a whole UART frame and enforces one byte per frame.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: byte width; equals the UART buffer width.
- `HEADER_EN`, 1: 1 = emit a header byte before each packet.
- `HEADER_BASE`, 8'hA0: header value is `HEADER_BASE | grant_id`. The low `ID_W` bits of `HEADER_BASE` must be 0.
- `TIMEOUT_CYCLES`, 65535: FETCH stall limit before the packet is aborted; 0 disables the timeout.
- Derived: `ID_W = max(1, $clog2(NUM_REQ))`; `TO_W = max(1, $clog2(TIMEOUT_CYCLES+1))`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_data`, in, `NUM_REQ*DATA_WIDTH`: requester i drives bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid`, in, `NUM_REQ`: requester i has a byte available.
- `req_last`, in, `NUM_REQ`: the byte is the last of its packet; qualified by `req_valid`.
- `req_ready`, out, `NUM_REQ`: byte of requester i is accepted when `req_valid[i] & req_ready[i]`.
- `uart_write_data`, out, `DATA_WIDTH`: to UART `write_data`.
- `uart_write_valid`, out, 1: to UART `write_valid`.
- `uart_write_ready`, in, 1: from UART `write_ready`.
- `grant_active`, out, 1: a packet is in progress.
- `grant_id`, out, `ID_W`: current or most recent grantee.
- `pkt_abort`, out, 1: one-cycle pulse when a packet is aborted by timeout.

## Operation
- **States:**
  - IDLE: no grant held.
  - HEADER: load the header byte.
  - FETCH: pull a payload byte from the grantee.
  - SEND: offer the held byte to the UART.
- **Round-robin:**
  - Pointer `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first.
  - In IDLE, the winner is the first asserted `req_valid` scanning from `(last_grant+1) mod NUM_REQ` upward, with wrap.
  - `last_grant` updates to the winner only on packet completion or abort.
- **IDLE:**
  - On any `req_valid`: register `grant_id`, set `grant_active`.
  - Next state: HEADER if `HEADER_EN`, else FETCH.
- **HEADER:**
  - Waits for `!tx_busy`.
  - Then `hold_data <= HEADER_BASE | grant_id`, `hold_last <= 0`, next state SEND.
- **FETCH:**
  - `req_ready[grant_id] = !tx_busy`; all other `req_ready` bits are 0.
  - On transfer: `hold_data <= req_data[grant_id]`, `hold_last <= req_last[grant_id]`, next state SEND.
  - A timeout counter runs only in FETCH and clears on entry. When it reaches `TIMEOUT_CYCLES`:
    - pulse `pkt_abort`;
    - update `last_grant`;
    - clear `grant_active`;
    - go to IDLE without fetching.
- **SEND:**
  - `uart_write_valid = 1`, `uart_write_data = hold_data`.
  - On `uart_write_valid & uart_write_ready`: set `tx_busy`.
  - If `hold_last`: go to IDLE, update `last_grant`, clear `grant_active`. Otherwise go to FETCH.
- **tx_busy:**
  - Set on handshake.
  - Clears only after `uart_write_ready` has been seen low, then high again (flag `seen_low`).
  - `hold_data` is never written while `tx_busy` is set.
- Packet lock: the grant is never preempted by other requesters until `req_last` is sent or the packet aborts.
- Unused/illegal state encoding: go to IDLE, with all outputs at their reset values.

## Timing
- **Reset values:**
  - `req_ready = 0`, `uart_write_valid = 0`, `uart_write_data = 0`.
  - `grant_active = 0`, `grant_id = 0`, `pkt_abort = 0`.
  - `tx_busy = 0`, `seen_low = 0`, `last_grant = NUM_REQ-1`, state IDLE.
- All outputs are decoded from registered state. `req_ready` is combinational from state and `tx_busy` only, never from `req_valid`.
- **Latency, UART idle, `HEADER_EN=1`:**
  - `req_valid` high in cycle N.
  - HEADER in N+1.
  - SEND, with `uart_write_valid` high, in N+2.
- **Latency, `HEADER_EN=0`:**
  - `req_ready` high in N+1.
  - `uart_write_valid` high in N+2.
- Back-to-back bytes: the next `req_ready` rises one cycle after `uart_write_ready` returns high.
- **Simultaneous events:**
  - Multiple `req_valid` in IDLE: resolved by the round-robin scan.
  - A request arriving during SEND of another packet's last byte is considered in the next IDLE cycle.
- Reset mid-frame: all state clears on the next edge. `uart_write_valid` is low on the first cycle after reset. The UART resets independently.

## Test plan
- **Single packet:** `NUM_REQ=4`, `HEADER_EN=1`, req 2 sends {0x11, 0x22 last} → UART receives 0xA2, 0x11, 0x22; `req_ready[2]` pulses exactly twice; `grant_active` falls after 0x22 is handshaken.
- **Round-robin fairness:** all four requesters continuously send 1-byte packets from reset → header order 0xA0, 0xA1, 0xA2, 0xA3, 0xA0.
- **Packet lock:** req 0 sends a 3-byte packet while req 1 asserts valid from the first byte → all req 0 bytes are sent before 0xA1; `req_ready[1] = 0` throughout.
- **Data stability:** during every UART frame, `uart_write_data` is constant from the handshake until `write_ready` rises again; `uart_write_valid` is never high while `tx_busy` is set.
- **Timeout:** `TIMEOUT_CYCLES=20`, req 3 sends one non-last byte then drops valid → `pkt_abort` pulses exactly once, 20 cycles after FETCH entry; the next grant goes to the lowest pending requester after 3.
- **Reset mid-packet:** `rst_n` low for 1 cycle during SEND → next cycle all outputs are at reset values; a subsequent req 1 packet is framed correctly.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Optionally prefixes each packet with a source-ID header byte; holds write data stable per frame.
module uart_tx_arbiter #(
  parameter int                    NUM_REQ        = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter bit                    HEADER_EN      = 1'b1,
  parameter logic [DATA_WIDTH-1:0] HEADER_BASE    = 8'hA0,
  parameter int                    TIMEOUT_CYCLES = 65535,
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         uart_write_data,
  output logic                          uart_write_valid,
  input  logic                          uart_write_ready,
  output logic                          grant_active,
  output logic [ID_W-1:0]               grant_id,
  output logic                          pkt_abort
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_FETCH  = 2'd2,
    S_SEND   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       grant_id_q, last_grant_q;
  logic                  grant_active_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  hold_last_q;
  logic                  tx_busy_q, seen_low_q;
  logic [TO_W-1:0]       to_cnt_q;

  logic                  win_found;
  logic [ID_W-1:0]       win_id, scan_id;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  to_hit, fetch_fire, send_fire;

  // Scan starts just after the previous grantee so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_id = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  assign sel_data   = DATA_WIDTH'(req_data >> (int'(grant_id_q) * DATA_WIDTH));
  assign to_hit     = (TIMEOUT_CYCLES != 0) && (state_q == S_FETCH) &&
                      (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
  assign fetch_fire = (state_q == S_FETCH) && !tx_busy_q && !to_hit && req_valid[grant_id_q];
  assign send_fire  = (state_q == S_SEND) && uart_write_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      grant_active_q <= 1'b0;
      hold_data_q    <= '0;
      hold_last_q    <= 1'b0;
      tx_busy_q      <= 1'b0;
      seen_low_q     <= 1'b0;
      to_cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_id_q     <= win_id;
            grant_active_q <= 1'b1;
          end
        end
        S_HEADER: begin
          if (!tx_busy_q) begin
            hold_data_q <= HEADER_BASE | DATA_WIDTH'(grant_id_q);
            hold_last_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (to_hit) begin
            last_grant_q   <= grant_id_q;
            grant_active_q <= 1'b0;
          end else if (fetch_fire) begin
            hold_data_q <= sel_data;
            hold_last_q <= req_last[grant_id_q];
          end
        end
        S_SEND: begin
          if (uart_write_ready && hold_last_q) begin
            last_grant_q   <= grant_id_q;
            grant_active_q <= 1'b0;
          end
        end
        default: grant_active_q <= 1'b0;
      endcase

      if (state_q != S_FETCH)
        to_cnt_q <= '0;
      else if (!to_hit && TIMEOUT_CYCLES != 0)
        to_cnt_q <= to_cnt_q + 1'b1;

      // The UART frame is over only once write_ready has dropped and come back.
      if (send_fire) begin
        tx_busy_q  <= 1'b1;
        seen_low_q <= 1'b0;
      end else if (tx_busy_q) begin
        if (!uart_write_ready)
          seen_low_q <= 1'b1;
        else if (seen_low_q) begin
          tx_busy_q  <= 1'b0;
          seen_low_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win_found) state_d = HEADER_EN ? S_HEADER : S_FETCH;
      S_HEADER: if (!tx_busy_q) state_d = S_SEND;
      S_FETCH: begin
        if (to_hit)          state_d = S_IDLE;
        else if (fetch_fire) state_d = S_SEND;
      end
      S_SEND:   if (uart_write_ready) state_d = hold_last_q ? S_IDLE : S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = '0;
    uart_write_valid = 1'b0;
    pkt_abort        = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!tx_busy_q && !to_hit) req_ready[grant_id_q] = 1'b1;
        pkt_abort = to_hit;
      end
      S_SEND:  uart_write_valid = 1'b1;
      default: ;
    endcase
  end

  assign uart_write_data = hold_data_q;
  assign grant_active    = grant_active_q;
  assign grant_id        = grant_id_q;

endmodule
